// File: rtl/burst_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : burst_line_adapter
// Brief    : Cacheline (LINE_W) <-> BEATS x BURST_W pmem burst adapter, one
//            transaction in flight. Optional watchdog via `BLA_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module burst_line_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter int TO_CYC  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic               err_o
);

  localparam int c_BEATS = LINE_W / BURST_W;
  localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_OFF_W = $clog2(LINE_W / 8);
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
  localparam logic [31:0] c_TO_LIM = 32'(TO_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0]   r_buf;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_read;
  logic                r_write;
  logic                r_resp;
  logic                w_last;
  logic                w_abort;
  logic [ADDR_W-1:0]   w_addr_aligned;
  logic                w_unused;

  assign w_addr_aligned = {address_i[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
  assign w_last         = resp_i && (r_cnt == c_LAST_BEAT);
  assign w_unused       = ^{address_i[c_OFF_W-1:0], c_TO_LIM};

`ifdef BLA_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TO_CYC + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_err;

  // Abort on the TO_CYC-th consecutive beat-less cycle of RD/WR.
  assign w_abort = !resp_i && (32'(r_to_cnt) == (c_TO_LIM - 32'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= (r_state == RD || r_state == WR) && w_abort;
      if ((r_state == RD || r_state == WR) && !resp_i && !w_abort)
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      else
        r_to_cnt <= '0;
    end
  end

  assign err_o = r_err;
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // Writeback takes priority; a concurrent fill is picked up after resp_o.
          if (write_i) begin
            r_buf   <= line_i;
            r_addr  <= w_addr_aligned;
            r_write <= 1'b1;
            r_state <= WR;
          end else if (read_i) begin
            r_addr  <= w_addr_aligned;
            r_read  <= 1'b1;
            r_state <= RD;
          end
        end
        RD: begin
          if (resp_i) begin
            r_buf[int'(r_cnt)*BURST_W +: BURST_W] <= burst_i;
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
          if (w_last || w_abort) begin
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_resp  <= 1'b1;
            r_state <= DONE;
          end
        end
        WR: begin
          if (resp_i)
            r_cnt <= r_cnt + c_CNT_W'(1);
          if (w_last || w_abort) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_resp  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign read_o    = r_read;
  assign write_o   = r_write;
  assign address_o = r_addr;
  assign resp_o    = r_resp;
  assign line_o    = r_resp ? r_buf : '0;
  assign burst_o   = (r_state == WR) ? r_buf[int'(r_cnt)*BURST_W +: BURST_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_burst_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_line_adapter
// Brief    : Directed + randomized bench for burst_line_adapter with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_line_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic         resp_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         err_o;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] model_buf;

  burst_line_adapter #(
    .LINE_W (256),
    .BURST_W(64),
    .ADDR_W (32),
    .TO_CYC (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ":read_o"},    read_o,    0);
    chk({tag, ":write_o"},   write_o,   0);
    chk({tag, ":resp_o"},    resp_o,    0);
    chk({tag, ":err_o"},     err_o,     0);
    chk({tag, ":address_o"}, address_o, 0);
    chk({tag, ":burst_o"},   burst_o,   0);
    chk({tag, ":line_o"},    line_o,    0);
  endtask

  // Idle cycles; optionally throws spurious pmem strobes that must be ignored.
  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_quiet("idle");
      resp_i  = spurious ? 1'($urandom) : 1'b0;
      burst_i = {$urandom, $urandom};
    end
    resp_i = 1'b0;
  endtask

  // One transaction. For reads, data supplies the pmem beats (beat k = data[k*64 +: 64]).
  // both=1 holds read_i alongside the write so a fill follows it.
  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [255:0] data,
                         input int min_gap, input int max_gap, input bit both,
                         input bit check_lat);
    logic [31:0]  exp_addr;
    logic [1:0]   exp_req;
    logic [255:0] exp_line;
    int           sent;
    int           n;
    int           gap;
    bit           done;
    bit           started;
    exp_addr  = addr & 32'hFFFF_FFE0;
    exp_req   = is_wr ? 2'b01 : 2'b10;
    exp_line  = data;
    address_i = addr;
    line_i    = is_wr ? data : {8{$urandom}};
    write_i   = is_wr;
    read_i    = !is_wr || both;
    resp_i    = 1'b0;
    sent = 0; n = 0; done = 0; started = 0;
    gap  = $urandom_range(max_gap, min_gap);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      chk("err_o", err_o, 0);
      if (resp_o) begin
        chk("resp_line", line_o, exp_line);
        chk("resp_req_low", {read_o, write_o}, 2'b00);
        chk("resp_addr_low", address_o, 0);
        chk("resp_beats", sent, 4);
        if (check_lat) chk("resp_latency", n, 5);
        done    = 1;
        write_i = 1'b0;
        read_i  = both;
        resp_i  = 1'b0;
      end else if (read_o || write_o) begin
        started = 1;
        chk("req_kind", {read_o, write_o}, exp_req);
        chk("address_o", address_o, exp_addr);
        chk("beats_pending", sent < 4, 1);
        if (is_wr) chk("burst_o", burst_o, data[sent*64 +: 64]);
        // Inputs after sampling must not matter.
        address_i = both ? address_i : $urandom;
        line_i    = {8{$urandom}};
        if (sent < 4 && gap == 0) begin
          resp_i  = 1'b1;
          burst_i = is_wr ? 64'({$urandom, $urandom}) : data[sent*64 +: 64];
          sent++;
          gap = $urandom_range(max_gap, min_gap);
        end else begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
          if (gap > 0) gap--;
        end
      end else begin
        chk("pre_start_quiet", {started, line_o != 256'd0}, 2'b00);
      end
    end
    chk("resp_seen", done, 1);
    model_buf = exp_line;
  endtask

  initial begin
    logic [255:0] d;
    int           sent;
    bit           is_wr;
    rst       = 1'b0;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    model_buf = '0;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    idle(2, 0);

    // Fill, zero-gap, fixed beats.
    run_txn(0, 32'h0000_1234,
            {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 0, 0, 0, 1);
    idle(2, 0);

    // Writeback with 2-cycle gaps between beats.
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1, 32'hABCD_EF5F, d, 2, 2, 0, 0);
    idle(2, 0);

    // Simultaneous read+write: write first, then the held read.
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(1, 32'h1000_0040, d, 0, 1, 1, 0);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(0, 32'h2000_0080, d, 0, 1, 0, 0);
    idle(2, 0);

    // Randomized mix with random gaps and spurious idle strobes.
    for (int t = 0; t < 8; t++) begin
      is_wr = 1'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_txn(is_wr, $urandom, d, 0, 3, 0, 0);
      idle($urandom_range(3, 1), 1);
    end

    // Spurious strobes in IDLE then a clean fill.
    idle(5, 1);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(0, 32'h0000_0100, d, 0, 0, 0, 1);
    idle(1, 0);

    // Reset after beat 2 of a fill.
    address_i = 32'h0000_8040;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    sent      = 0;
    for (int c = 0; c < 20 && sent < 3; c++) begin
      @(negedge clk);
      if (read_o && sent < 3) begin
        resp_i  = 1'b1;
        burst_i = {$urandom, $urandom};
        sent++;
      end
    end
    chk("rst_setup_beats", sent, 3);
    @(negedge clk);
    rst     = 1'b0;
    resp_i  = 1'b0;
    read_i  = 1'b0;
    @(negedge clk);
    chk_quiet("midburst_reset");
    @(negedge clk);
    chk_quiet("midburst_reset_hold");
    rst       = 1'b1;
    model_buf = '0;
    idle(3, 0);
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_txn(0, 32'h0000_8040, d, 0, 2, 0, 0);
    idle(2, 0);

`ifdef BLA_TIMEOUT_EN
    // Fill with no pmem response: watchdog abort after 8 idle RD cycles.
    address_i = 32'h0000_3000;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n < 9) begin
        chk("to_read_o", read_o, 1);
        chk("to_no_resp", {resp_o, err_o}, 2'b00);
      end else begin
        chk("to_err_resp", {resp_o, err_o}, 2'b11);
        chk("to_read_drop", read_o, 0);
        chk("to_stale_line", line_o, model_buf);
        read_i = 1'b0;
      end
    end
    idle(3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
